// File: rtl/bus_slave_mem.sv
// Word-addressed bus slave: 2^ADDR_W x 32 register file behind the cs_n/as_n/rw/rdy_n handshake.
// Latency: s_rdy_n low for one cycle, WAIT_CYCLES+1 cycles after the accept cycle; outputs registered.
// Backpressure: one access at a time; strobes are ignored outside IDLE; cs_n high in WAIT aborts.
// Optional: define BUS_SLAVE_MEM_ID_REG_EN to make index 0 a read-only ID register.
module bus_slave_mem #(
    parameter int          ADDR_W      = 6,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] ID_VALUE    = 32'h415A_5052
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        s_cs_n,
    input  logic        s_as_n,
    input  logic        s_rw,
    input  logic [29:0] s_addr,
    input  logic [31:0] s_wr_data,
    output logic [31:0] s_rd_data,
    output logic        s_rdy_n
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_READY = 2'd2;

    logic [1:0]        state;
    logic [3:0]        wait_cnt;
    logic [ADDR_W-1:0] idx_q;
    logic              rw_q;
    logic [31:0]       wr_data_q;

    logic [31:0]       mem [0:(1<<ADDR_W)-1];

    logic              accept;
    logic              to_ready;
    logic [ADDR_W-1:0] rd_idx;
    logic              rd_dir;
    logic [31:0]       rd_word;
    logic              wr_blocked;
    logic              unused_addr_hi;

    // Upper address bits are don't-care: the array aliases across them.
    assign unused_addr_hi = ^s_addr[29:ADDR_W];

    assign accept   = (state == ST_IDLE) && !s_cs_n && !s_as_n;
    // Cycle in which the FSM moves into READY; drives the registered outputs.
    assign to_ready = (accept && (WAIT_CYCLES == 0)) ||
                      ((state == ST_WAIT) && !s_cs_n && (wait_cnt == 4'd0));

    // With zero wait states READY follows accept directly, so the read
    // must use the inputs being latched on that same edge.
    assign rd_idx = (state == ST_IDLE) ? s_addr[ADDR_W-1:0] : idx_q;
    assign rd_dir = (state == ST_IDLE) ? s_rw : rw_q;

`ifdef BUS_SLAVE_MEM_ID_REG_EN
    assign wr_blocked = (idx_q == '0);
`else
    assign wr_blocked = 1'b0;
`endif

    // Read mux: storage word, overridden by the ID constant at index 0 when enabled.
    always_comb begin
        rd_word = mem[rd_idx];
`ifdef BUS_SLAVE_MEM_ID_REG_EN
        if (rd_idx == '0) begin
            rd_word = ID_VALUE;
        end
`endif
    end

    // Access FSM: accept and latch in IDLE, count wait states, single READY cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            wait_cnt  <= 4'd0;
            idx_q     <= '0;
            rw_q      <= 1'b1;
            wr_data_q <= 32'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        idx_q     <= s_addr[ADDR_W-1:0];
                        rw_q      <= s_rw;
                        wr_data_q <= s_wr_data;
                        if (WAIT_CYCLES == 0) begin
                            state <= ST_READY;
                        end else begin
                            wait_cnt <= 4'(WAIT_CYCLES - 1);
                            state    <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (s_cs_n) begin
                        state    <= ST_IDLE;
                        wait_cnt <= 4'd0;
                    end else if (wait_cnt == 4'd0) begin
                        state <= ST_READY;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                ST_READY: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Registered outputs: rdy_n and read data only during the READY cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            s_rdy_n   <= 1'b1;
            s_rd_data <= 32'd0;
        end else begin
            s_rdy_n   <= !to_ready;
            s_rd_data <= (to_ready && rd_dir) ? rd_word : 32'd0;
        end
    end

    // Write commits on the edge that ends READY; reset drops it.
    always_ff @(posedge clk) begin
        if (!reset && (state == ST_READY) && !rw_q && !wr_blocked) begin
            mem[idx_q] <= wr_data_q;
        end
    end

endmodule

// File: doc/bus_slave_mem.md
# bus_slave_mem

Generic word-addressed responder for the shared SoC bus. It sits on one slave slot behind `bus_top`'s address decoder and slave multiplexer, and answers master accesses on the `cs_n` / `as_n` / `rw` / `rdy_n` handshake. It holds a 2^ADDR_W-word register file and inserts a fixed, parameterised number of wait states before signalling ready. It is the first real slave used to close the loop on bus arbitration and multiplexing in system benches.

## Interface
Parameters:
- ADDR_W, default 6: index width; the array has 2^ADDR_W 32-bit words, indexed by `s_addr[ADDR_W-1:0]`.
- WAIT_CYCLES, default 2: wait states inserted between the accept cycle and the ready cycle; legal range 0–15.
- ID_VALUE, default 32'h415A_5052: constant returned from word 0 when the ID register is compiled in.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- s_cs_n  in  1  chip select from the address decoder, active low.
- s_as_n  in  1  address strobe, active low.
- s_rw  in  1  access direction: `READ` = 1, `WRITE` = 0.
- s_addr  in  30  word address (`WORD_ADDR_BUS`); bits above ADDR_W-1 are ignored, so the array aliases.
- s_wr_data  in  32  write data (`WORD_DATA_BUS`).
- s_rd_data  out  32  read data; valid only while `s_rdy_n` = 0, otherwise 0.
- s_rdy_n  out  1  ready, active low; asserted for exactly one cycle per access.

## Operation
- The block has three states: IDLE, WAIT and READY.
- IDLE:
  - An access is accepted on a rising edge where `s_cs_n`=0 and `s_as_n`=0.
  - On accept, latch `s_addr[ADDR_W-1:0]`, `s_rw` and `s_wr_data`.
  - If WAIT_CYCLES=0, go to READY. Otherwise load the wait counter with WAIT_CYCLES-1 and go to WAIT.
- WAIT:
  - The counter decrements each cycle; at 0, go to READY.
  - If `s_cs_n` is sampled 1 (access withdrawn), go to IDLE. No write occurs and `rdy_n` is never asserted.
- READY:
  - `s_rdy_n`=0 for this one cycle.
  - For a read, `s_rd_data` = mem[latched index].
  - For a write, mem[latched index] is updated at the edge that ends READY.
  - The state returns to IDLE unconditionally.
- Strobes sampled in WAIT or READY are ignored; there is no queuing and no pipelining.
- Latched address, data and rw are used throughout the access. Input changes after accept have no effect, except the `s_cs_n` withdrawal described above.
- Memory contents are not cleared by reset; they are undefined until first written.

## Timing
- Reset values: state=IDLE, `s_rdy_n`=1, `s_rd_data`=0, wait counter=0.
- Reset asserted mid-access: the next state is IDLE, `rdy_n` stays 1 and any pending write is dropped.
- Latency: accept at edge E puts READY in the cycle after edge E+WAIT_CYCLES. `s_rdy_n` is low during cycle E+1+WAIT_CYCLES, i.e. WAIT_CYCLES+1 cycles after the accept cycle.
- Both outputs are registered (driven from state and latched data); there are no combinational paths from inputs to outputs.
- The master samples `rdy_n`=0 at the edge ending READY and releases `as_n` in the next cycle. A strobe still low in the first IDLE cycle after READY is a new access. Back-to-back accesses therefore have a throughput of one access per WAIT_CYCLES+2 cycles.
- Write followed by a read of the same word: the read returns the new value, because the write commits before the next accept.

## Configuration
- Macro: `BUS_SLAVE_MEM_ID_REG_EN`.
- Defined:
  - Index 0 is a read-only ID register: reads return ID_VALUE.
  - Writes to index 0 complete normally (`rdy_n` pulses) but do not change storage.
- Undefined: index 0 is an ordinary read/write word.

## Test plan
- Reset: hold `reset`=1 for 3 cycles with `s_cs_n`=`s_as_n`=0 -> `s_rdy_n`=1 and `s_rd_data`=0 throughout; no access starts.
- Write then read, WAIT_CYCLES=2:
  - Write 32'h0000_1234 to addr 30'h3, then read addr 30'h3.
  - Required: `rdy_n` low exactly 3 cycles after each accept, for one cycle; the read returns 32'h0000_1234; `rd_data`=0 outside the ready cycle.
- Aliasing and zero-wait, WAIT_CYCLES=0:
  - Write 32'hDEAD_BEEF to addr 30'h0000_0045 (ADDR_W=6), then read addr 30'h5.
  - Required: 32'hDEAD_BEEF returned, `rdy_n` one cycle after each accept.
- Abort:
  - Start a write of 32'h5678 to addr 30'h7, then deassert `s_cs_n` during WAIT.
  - Required: no `rdy_n` pulse; a later read of addr 30'h7 returns the old value.
- Reset mid-access:
  - Assert `reset` in the WAIT cycle of a write of 32'hAAAA to addr 30'h9.
  - Required: `rdy_n` stays 1; a subsequent read of addr 30'h9 does not return 32'hAAAA (word pre-written to 32'h1).
- ID register, macro defined:
  - Write 32'hFFFF_FFFF to addr 30'h0, then read addr 30'h0.
  - Required: `rdy_n` pulses for both accesses; the read returns 32'h415A_5052.
  - Macro undefined: the read returns 32'hFFFF_FFFF.
